ps2_tx_multi: RTL

- Parametrised multi-channel PS/2 device-side transmitter for the clk_sys domain.
- Successor to the keyboard/mouse FIFO+serialiser pair in the ARM I/O block; generalised to NCH channels and configurable FIFO depth.
- Adds a full-depth FIFO, a sticky overflow flag, host-inhibit detection, and retransmission of an aborted byte.
- Sits between the SPI command decoder (byte strobes) and the core's PS/2 controllers.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_tx_chan.sv | 141 ++++++++++++++
 rtl/ps2_tx_multi.sv | 76 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel PS/2 transmitter.
package ps2_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_PAR  = 4'd9;
    localparam logic [3:0] ST_STOP = 4'd10;
    localparam logic [3:0] ST_DONE = 4'd11;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if (v > (32'd1 << i)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Select width for NCH channels; a single channel still needs a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned nch);
        return (clog2(nch) > 1) ? clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ps2_tx_chan.sv
// One PS/2 transmit channel: byte FIFO, frame serialiser, host-inhibit sensing, overflow flag.
module ps2_tx_chan
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       clk_ps2,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       clr_overflow,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int unsigned DEPTH = 2 ** FIFO_BITS;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wptr;
    logic [FIFO_BITS:0] rptr;
    logic [3:0]         state;
    logic [7:0]         shift;
    logic               parity;
    logic               data_q;
    logic               clk_out_d;
    logic               inh_raw;
    logic               inh_s1;
    logic               inh_s2;
    logic               inh_pend;
    logic               inhibited;
    logic               pop;
    logic               push;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                        (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);

    assign push = wr && !fifo_full;
    assign pop  = tick && (state == ST_DONE);

    assign ps2_clk_out  = clk_ps2 | (state == ST_IDLE);
    assign ps2_data_out = data_q;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wptr[FIFO_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (wr && fifo_full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Host pull-down only counts once our clock has been released for a full cycle,
    // and is remembered across the low half-period so the next tick can act on it.
    assign inh_raw   = ~ps2_clk_in & ps2_clk_out & clk_out_d;
    assign inhibited = inh_pend | inh_s2;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_out_d <= 1'b1;
            inh_s1    <= 1'b0;
            inh_s2    <= 1'b0;
            inh_pend  <= 1'b0;
        end else begin
            clk_out_d <= ps2_clk_out;
            inh_s1    <= inh_raw;
            inh_s2    <= inh_s1;
            inh_pend  <= tick ? 1'b0 : (inh_pend | inh_s2);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            shift  <= '0;
            parity <= 1'b0;
            data_q <= 1'b1;
        end else if (tick) begin
            if (inhibited && (state != ST_IDLE) && (state != ST_DONE)) begin
                state  <= ST_IDLE;
                data_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        data_q <= 1'b1;
                        if (!fifo_empty && !inhibited) begin
                            shift  <= mem[rptr[FIFO_BITS-1:0]];
                            parity <= 1'b1;
                            data_q <= 1'b0;
                            state  <= 4'd1;
                        end
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        data_q <= shift[0];
                        shift  <= {1'b0, shift[7:1]};
                        if (shift[0]) begin
                            parity <= ~parity;
                        end
                        state <= state + 4'd1;
                    end
                    ST_PAR: begin
                        data_q <= parity;
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        data_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                    default: begin
                        data_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device-side transmitter: shared PS/2 clock divider feeding NCH channels.
module ps2_tx_multi
    import ps2_pkg::*;
#(
    parameter  int unsigned NCH       = 2,
    parameter  int unsigned FIFO_BITS = 3,
    parameter  int unsigned PS2DIV    = 100,
    localparam int unsigned CHW       = ch_width(NCH)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             wr,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [7:0]       wr_data,
    input  logic             clr_overflow,
    input  logic [NCH-1:0]   ps2_clk_in,
    output logic [NCH-1:0]   ps2_clk_out,
    output logic [NCH-1:0]   ps2_data_out,
    output logic [NCH-1:0]   fifo_full,
    output logic [NCH-1:0]   fifo_empty,
    output logic [NCH-1:0]   overflow
);

    localparam int unsigned     CNTW    = ch_width(PS2DIV + 1);
    localparam logic [CNTW-1:0] DIV_END = CNTW'(PS2DIV);

    logic [CNTW-1:0] cnt;
    logic            clk_ps2;
    logic            tick;
    logic [NCH-1:0]  wr_sel;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_ps2 <= 1'b0;
        end else if (cnt == DIV_END) begin
            cnt     <= '0;
            clk_ps2 <= ~clk_ps2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Channel FSMs advance on the same edge that raises clk_ps2.
    assign tick = (cnt == DIV_END) && !clk_ps2;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (wr && (wr_ch == CHW'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        ps2_tx_chan #(
            .FIFO_BITS(FIFO_BITS)
        ) u_chan (
            .clk_sys     (clk_sys),
            .reset       (reset),
            .tick        (tick),
            .clk_ps2     (clk_ps2),
            .wr          (wr_sel[g]),
            .wr_data     (wr_data),
            .clr_overflow(clr_overflow),
            .ps2_clk_in  (ps2_clk_in[g]),
            .ps2_clk_out (ps2_clk_out[g]),
            .ps2_data_out(ps2_data_out[g]),
            .fifo_full   (fifo_full[g]),
            .fifo_empty  (fifo_empty[g]),
            .overflow    (overflow[g])
        );
    end

endmodule
